// File: rtl/xor_parity_pkg.sv
// rtl/xor_parity_pkg.sv - shared state encoding and parity-mode constants for xor_parity_checker
package xor_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/xor_gate.sv
// rtl/xor_gate.sv - single-bit XOR datapath element
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_parity_checker.sv
// rtl/xor_parity_checker.sv - serial frame parity checker: DATA_W data bits, LSB first, then one parity bit
module xor_parity_checker
  import xor_parity_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter logic ODD    = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_ok,
  output logic              done
);

  localparam int             CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_acc;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic                r_parity_ok;
  logic                w_acc_next;

  xor_gate u_acc_xor (
    .a (r_acc),
    .b (bit_in),
    .y (w_acc_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = DATA;
      DATA:    if (bit_valid && (r_cnt == LAST_BIT)) w_state_next = PARITY;
      PARITY:  if (bit_valid) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_shift     <= '0;
      r_data      <= '0;
      r_parity_ok <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_shift <= '0;
          end
        end
        DATA: begin
          // Right shift so the first accepted bit ends up at bit 0.
          if (bit_valid) begin
            r_shift <= {bit_in, r_shift[DATA_W-1:1]};
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_valid) begin
            r_data      <= r_shift;
            r_parity_ok <= (w_acc_next == ODD);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign data_out  = r_data;
  assign parity_ok = r_parity_ok;

endmodule

// File: tb/tb_xor_parity_checker.sv
// tb/tb_xor_parity_checker.sv - directed table-driven bench for xor_parity_checker, even and odd instances
module tb_xor_parity_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       busy_e, done_e, pok_e;
  logic       busy_o, done_o, pok_o;
  logic [7:0] data_e, data_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_parity_checker #(.DATA_W(8), .ODD(1'b0)) u_even (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy_e),
    .data_out  (data_e),
    .parity_ok (pok_e),
    .done      (done_e)
  );

  xor_parity_checker #(.DATA_W(8), .ODD(1'b1)) u_odd (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy_o),
    .data_out  (data_o),
    .parity_ok (pok_o),
    .done      (done_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         stall;
    bit         mid_start;
    bit         hold_start;
    int         exp_edge;
    logic       pok_even;
    logic       pok_odd;
  } vec_t;

  vec_t vecs[6];
  vec_t v_ff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int         e;
    bit         early_done;
    logic [8:0] bits;
    string      tag;
    tag        = $sformatf("f%0d", idx);
    bits       = {v.par, v.data};
    early_done = 1'b0;
    start      = 1'b1;
    bit_valid  = 1'b0;
    tick();
    start = 1'b0;
    e     = 0;
    for (int k = 0; k < 9; k++) begin
      if (v.stall) begin
        bit_valid = 1'b0;
        bit_in    = ~bits[k];
        start     = v.mid_start && (k == 3);
        tick();
        e++;
        start = 1'b0;
        if (done_e || done_o) early_done = 1'b1;
      end
      bit_valid = 1'b1;
      bit_in    = bits[k];
      start     = v.mid_start && !v.stall && (k == 3);
      tick();
      e++;
      start = 1'b0;
      if (k < 8 && (done_e || done_o)) early_done = 1'b1;
    end
    bit_valid = 1'b0;
    chk({tag, "_early_done"}, 32'(early_done), 32'd0);
    chk({tag, "_done_e"},     32'(done_e),     32'd1);
    chk({tag, "_done_o"},     32'(done_o),     32'd1);
    chk({tag, "_done_edge"},  32'(e),          32'(v.exp_edge));
    chk({tag, "_busy_done"},  32'(busy_e),     32'd1);
    chk({tag, "_data_e"},     32'(data_e),     32'(v.data));
    chk({tag, "_data_o"},     32'(data_o),     32'(v.data));
    chk({tag, "_pok_e"},      32'(pok_e),      32'(v.pok_even));
    chk({tag, "_pok_o"},      32'(pok_o),      32'(v.pok_odd));
    start = v.hold_start;
    tick();
    start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done_e),     32'd0);
    chk({tag, "_busy_e_end"}, 32'(busy_e),     32'd0);
    chk({tag, "_busy_o_end"}, 32'(busy_o),     32'd0);
    chk({tag, "_data_hold"},  32'(data_e),     32'(v.data));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;

    //            data   par   stall mid   hold  edge  even  odd
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 9,  1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b0};
    vecs[2] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 9,  1'b0, 1'b1};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 18, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9,  1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b0};
    v_ff    = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b0};

    // Reset state, with bit_valid asserted to show it is ignored in IDLE.
    tick();
    tick();
    rst       = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("rst_busy",  32'(busy_e), 32'd0);
    chk("rst_done",  32'(done_e), 32'd0);
    chk("rst_data",  32'(data_e), 32'd0);
    chk("rst_pok_e", 32'(pok_e),  32'd0);
    chk("rst_pok_o", 32'(pok_o),  32'd0);

    // Frames run back-to-back: each new start is raised right after busy drops.
    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Abort mid-frame: 4 data bits then reset; nothing may be published.
    start = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_busy", 32'(busy_e), 32'd1);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    bit_valid = 1'b0;
    chk("midrst_busy",  32'(busy_e), 32'd0);
    chk("midrst_done",  32'(done_e), 32'd0);
    chk("midrst_data",  32'(data_e), 32'd0);
    chk("midrst_pok_e", 32'(pok_e),  32'd0);
    chk("midrst_pok_o", 32'(pok_o),  32'd0);
    tick();
    chk("midrst_idle", 32'(busy_e | done_e), 32'd0);
    run_frame(v_ff, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
